boot_loader: RTL and testbench

Instruction-image loader sitting upstream of the 5-stage pipeline core. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them to sequential instruction-memory addresses starting at 0. It holds the core in reset (`core_rst_n` low) until the requested number of words has been written, then releases it so Fetch starts from a fully loaded image.

---
 rtl/boot_pkg.sv | 15 +
 rtl/byte_packer.sv | 44 ++++
 rtl/boot_loader.sv | 129 ++++++++++++
 tb/tb_boot_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types for the instruction-image boot loader.
// States and word geometry used by the loader FSM and byte packer.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Byte-lane insert register: assembles a little-endian word
// one byte at a time; full marks the write that fills the top lane.
module byte_packer
  import boot_pkg::*;
#(
  parameter int LANES = BYTES_PER_WORD,
  parameter int LW    = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [LW-1:0]     lane,
  input  logic [7:0]        din,
  output logic [8*LANES-1:0] word,
  output logic              full
);

  localparam logic [LW-1:0] TOP = LW'(LANES - 1);

  logic [8*LANES-1:0] word_q;
  logic [8*LANES-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (we) begin
      word_d[8*lane +: 8] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;
  assign full = we && (lane == TOP);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams bytes into instruction memory, then
// releases the core from reset once the full image is written.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANES = WORD_W / 8;
  localparam int LW    = $clog2(LANES);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [LW-1:0]   LONE  = LW'(1);

  boot_state_t     state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [LW-1:0]   bcnt_q, bcnt_d;

  logic pk_clr;
  logic pk_we;
  logic pk_full;

  byte_packer #(
    .LANES (LANES)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (pk_clr),
    .we    (pk_we),
    .lane  (bcnt_q),
    .din   (byte_data),
    .word  (imem_wdata),
    .full  (pk_full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    pk_clr  = 1'b0;
    pk_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          len_d  = load_words;
          wcnt_d = '0;
          bcnt_d = '0;
          pk_clr = 1'b1;
          if (load_words > DEPTH) begin
            state_d = ERR;
          end else if (load_words == '0) begin
            state_d = DONE;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          pk_we  = 1'b1;
          bcnt_d = bcnt_q + LONE;
          if (pk_full) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wcnt_d = wcnt_q + ONE;
        bcnt_d = '0;
        pk_clr = 1'b1;
        // wcnt is one bit wider than the address, so 2^ADDR_W never wraps
        if (wcnt_q + ONE == len_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
      end
      ERR: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign byte_ready = (state_q == RECV);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = wcnt_q[ADDR_W-1:0];
  assign core_rst_n = (state_q == DONE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed loads plus randomized
// byte pacing, checked against a queue-based image model.
module tb_boot_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  boot_loader #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_words (load_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  src[$];
  int          wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
  end

  int t_ls, t_last, t_done, n_acc;
  bit timed_out;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".core_rst_n"}, 64'(core_rst_n), 64'(0));
    chk({tag, ".byte_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, ".imem_we"}, 64'(imem_we), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".err"}, 64'(err), 64'(0));
    chk({tag, ".imem_addr"}, 64'(imem_addr), 64'(0));
    chk({tag, ".imem_wdata"}, 64'(imem_wdata), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // mode 0: valid held, 1: toggled, 2: random ~75%
  task automatic run_load(input int n, input int mode, input int stop_after);
    int budget;
    int idx;
    bit tog;
    @(negedge clk);
    load_words = (ADDR_W+1)'(n);
    load_start = 1'b1;
    t_ls = cyc;
    @(negedge clk);
    load_start = 1'b0;
    budget = 20000;
    idx = 0;
    tog = 1'b1;
    timed_out = 1'b0;
    while (!(done || err) && idx != stop_after && budget > 0) begin
      bit v;
      case (mode)
        0: v = 1'b1;
        1: v = tog;
        default: v = ($urandom_range(3) != 0);
      endcase
      tog = ~tog;
      byte_valid = v && (idx < src.size());
      byte_data = (idx < src.size()) ? src[idx] : 8'($urandom);
      if (byte_valid && byte_ready) begin
        idx++;
        t_last = cyc;
      end
      @(negedge clk);
      budget--;
    end
    byte_valid = 1'b0;
    t_done = cyc;
    n_acc = idx;
    timed_out = (budget == 0);
  endtask

  task automatic chk_image(input string tag, input int n);
    chk({tag, ".nwrites"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      logic [31:0] e;
      e = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
      chk($sformatf("%s.addr%0d", tag, i), 64'(wa[i]), 64'(i));
      chk($sformatf("%s.data%0d", tag, i), 64'(wd[i]), 64'(e));
    end
  endtask

  initial begin
    // Reset state, then 20 idle cycles with no load_start
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_idle_outputs("idle20");

    // Two-word directed load, valid held high
    do_reset();
    src = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00};
    run_load(2, 0, -1);
    chk("two.timeout", 64'(timed_out), 64'(0));
    chk_image("two", 2);
    chk("two.word0", 64'(wd.size() > 0 ? wd[0] : 0), 64'h00500013);
    chk("two.word1", 64'(wd.size() > 1 ? wd[1] : 0), 64'h000002B3);
    chk("two.we_latency", 64'(wc.size() > 1 ? wc[1] - t_ls : -1), 64'(10));
    chk("two.done_latency", 64'(t_done - t_last), 64'(2));
    chk("two.done", 64'(done), 64'(1));
    chk("two.core_rst_n", 64'(core_rst_n), 64'(1));
    chk("two.busy", 64'(busy), 64'(0));
    // load_start in DONE is ignored
    @(negedge clk);
    load_start = 1'b1;
    load_words = 9'd1;
    @(negedge clk);
    load_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("two.ignore_start", 64'({done, busy, byte_ready}), 64'(3'b100));
    chk("two.no_extra_we", 64'(wa.size()), 64'(2));

    // One word, valid toggled every cycle
    do_reset();
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 1, -1);
    chk("tog.timeout", 64'(timed_out), 64'(0));
    chk_image("tog", 1);
    chk("tog.word", 64'(wd.size() > 0 ? wd[0] : 0), 64'h44332211);
    chk("tog.accepted", 64'(n_acc), 64'(4));
    chk("tog.done", 64'(done), 64'(1));

    // Zero-length load: DONE on the next cycle
    do_reset();
    src.delete();
    run_load(0, 0, -1);
    chk("zero.done_next", 64'(t_done - t_ls), 64'(1));
    chk("zero.done", 64'(done), 64'(1));
    chk("zero.core_rst_n", 64'(core_rst_n), 64'(1));
    chk("zero.nwrites", 64'(wa.size()), 64'(0));

    // Oversized load: ERR, core held in reset
    do_reset();
    run_load(257, 0, -1);
    repeat (5) @(negedge clk);
    chk("over.err", 64'(err), 64'(1));
    chk("over.core_rst_n", 64'(core_rst_n), 64'(0));
    chk("over.done", 64'(done), 64'(0));
    chk("over.byte_ready", 64'(byte_ready), 64'(0));
    chk("over.nwrites", 64'(wa.size()), 64'(0));

    // Full-depth load with random pacing and data
    do_reset();
    src.delete();
    for (int i = 0; i < 4 * 256; i++) src.push_back(8'($urandom));
    run_load(256, 2, -1);
    chk("full.timeout", 64'(timed_out), 64'(0));
    chk_image("full", 256);
    chk("full.last_addr", 64'(wa.size() > 0 ? wa[wa.size()-1] : -1), 64'(255));
    chk("full.done", 64'(done), 64'(1));
    chk("full.core_rst_n", 64'(core_rst_n), 64'(1));
    chk("full.accepted", 64'(n_acc), 64'(1024));

    // Reset asserted after 2 bytes of word 3
    do_reset();
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
    run_load(5, 2, 14);
    chk("mid.accepted", 64'(n_acc), 64'(14));
    chk("mid.busy_before", 64'(busy), 64'(1));
    chk("mid.nwrites_before", 64'(wa.size()), 64'(3));
    #2 rst = 1'b0;
    #1 chk_idle_outputs("mid_async");
    @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
    wc.delete();
    src.delete();
    for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
    run_load(1, 0, -1);
    chk("mid.timeout", 64'(timed_out), 64'(0));
    chk_image("mid_reload", 1);
    chk("mid.done", 64'(done), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
